// File: rtl/rs_chien_ctrl_if.sv
// rs_chien_ctrl_if: handshake bundle around the Chien search engine.
//   Lambda side : lambda_vld/lambda_rdy handshake carrying the error-locator polynomial
//                 (lambda[i] is the coefficient of x^i) and the degree claimed by BM.
//   Chien side  : chien_vld/chien_rdy handshake carrying one chunk per beat
//                 (chien_base, chien_mask, chien_last) plus err_cnt and fail.
// Modports:
//   master - the surrounding decoder (drives lambda, consumes chunks)
//   slave  - the Chien engine itself
interface rs_chien_ctrl_if #(
  parameter int unsigned ROOTS_PER_CYCLE = 4,
  parameter int unsigned T_LEN           = 8,
  parameter int unsigned SYMB_WIDTH      = 8,
  parameter int unsigned LEN_WIDTH       = 8
);
  logic                               lambda_vld;
  logic                               lambda_rdy;
  logic [T_LEN:0][SYMB_WIDTH-1:0]     lambda;
  logic [LEN_WIDTH-1:0]               lambda_deg;
  logic                               chien_vld;
  logic                               chien_rdy;
  logic [SYMB_WIDTH-1:0]              chien_base;
  logic [ROOTS_PER_CYCLE-1:0]         chien_mask;
  logic                               chien_last;
  logic [SYMB_WIDTH-1:0]              err_cnt;
  logic                               fail;

  modport master (
    output lambda_vld, lambda, lambda_deg, chien_rdy,
    input  lambda_rdy, chien_vld, chien_base, chien_mask, chien_last, err_cnt, fail
  );

  modport slave (
    input  lambda_vld, lambda, lambda_deg, chien_rdy,
    output lambda_rdy, chien_vld, chien_base, chien_mask, chien_last, err_cnt, fail
  );
endinterface

// File: rtl/rs_chien_ctrl.sv
// rs_chien_ctrl: sequenced Chien search over GF(2^8) (poly 0x11D), N_LEN = 255 positions.
// Accepts one error-locator polynomial per codeword and sweeps ROOTS_PER_CYCLE positions per
// chunk, flagging position j when Lambda(alpha^-j) = 0.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - rs_chien_ctrl_if.slave (lambda handshake in, chunk stream out)
// Datapath: term_q[i] holds lambda[i] * alpha^(-i*base). Each mask bit k multiplies the terms
// by the constants alpha^(-i*k) and XOR-sums them; stepping a chunk multiplies every term by
// alpha^(-i*R). All constants are folded at elaboration.
module rs_chien_ctrl #(
  parameter int unsigned ROOTS_PER_CYCLE = 4
) (
  input logic            clk,
  input logic            rst,
  rs_chien_ctrl_if.slave bus
);
  localparam int unsigned N_LEN      = 255;
  localparam int unsigned T_LEN      = 8;
  localparam int unsigned SYMB_WIDTH = 8;
  localparam int unsigned POLY       = 285;
  localparam int unsigned LEN_WIDTH  = 8;
  localparam int unsigned R          = ROOTS_PER_CYCLE;
  localparam logic [7:0]  PolyLow    = 8'(POLY);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  function automatic symb_t gf_xtime(symb_t a);
    return a[7] ? ((a << 1) ^ PolyLow) : (a << 1);
  endfunction

  function automatic symb_t gf_mul(symb_t a, symb_t b);
    symb_t p;
    symb_t s;
    p = '0;
    s = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ s;
      s = gf_xtime(s);
    end
    return p;
  endfunction

  function automatic symb_t alpha_pow(int unsigned e);
    symb_t r;
    r = 8'h01;
    for (int unsigned i = 0; i < e; i++) r = gf_xtime(r);
    return r;
  endfunction

  state_e               state_q;
  logic                 lambda_rdy_q;
  logic                 chien_vld_q;
  symb_t                term_q [T_LEN+1];
  symb_t                base_q;
  symb_t                acc_q;
  logic [LEN_WIDTH-1:0] deg_q;
  logic                 lam0_zero_q;

  symb_t                step_term [T_LEN+1];
  symb_t                prod [R][T_LEN+1];
  symb_t                eval [R];
  logic [R-1:0]         mask;
  logic                 last;
  logic                 in_search;
  symb_t                popcnt;
  symb_t                err_total;
  int unsigned          base_int;

  for (genvar i = 0; i <= T_LEN; i++) begin : g_term
    localparam symb_t Step = alpha_pow((N_LEN - (i * R) % N_LEN) % N_LEN);
    assign step_term[i] = gf_mul(term_q[i], Step);
    for (genvar k = 0; k < R; k++) begin : g_root
      localparam symb_t Coef = alpha_pow((N_LEN - (i * k) % N_LEN) % N_LEN);
      assign prod[k][i] = gf_mul(term_q[i], Coef);
    end
  end

  always_comb begin
    in_search = (state_q == StSearch);
    base_int  = 32'(base_q);
    last      = in_search && (base_int + R >= N_LEN);
    mask      = '0;
    popcnt    = '0;
    for (int k = 0; k < R; k++) begin
      eval[k] = '0;
      for (int i = 0; i <= T_LEN; i++) eval[k] = eval[k] ^ prod[k][i];
      // Positions past the end of the codeword never report, and nothing reports in IDLE.
      if (in_search && (base_int + unsigned'(k) < N_LEN) && (eval[k] == '0)) mask[k] = 1'b1;
      popcnt = popcnt + SYMB_WIDTH'(mask[k]);
    end
    err_total = acc_q + popcnt;
  end

  assign bus.lambda_rdy = lambda_rdy_q;
  assign bus.chien_vld  = chien_vld_q;
  assign bus.chien_base = base_q;
  assign bus.chien_mask = mask;
  assign bus.chien_last = last;
  assign bus.err_cnt    = err_total;
  assign bus.fail       = last && ((err_total != deg_q) || (32'(deg_q) > T_LEN) || lam0_zero_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lambda_rdy_q <= 1'b1;
      chien_vld_q  <= 1'b0;
      base_q       <= '0;
      acc_q        <= '0;
      deg_q        <= '0;
      lam0_zero_q  <= 1'b0;
      for (int i = 0; i <= T_LEN; i++) term_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.lambda_vld) begin
            state_q      <= StSearch;
            lambda_rdy_q <= 1'b0;
            chien_vld_q  <= 1'b1;
            base_q       <= '0;
            acc_q        <= '0;
            deg_q        <= bus.lambda_deg;
            lam0_zero_q  <= (bus.lambda[0] == '0);
            for (int i = 0; i <= T_LEN; i++) term_q[i] <= bus.lambda[i];
          end
        end
        StSearch: begin
          if (bus.chien_rdy) begin
            acc_q <= err_total;
            if (last) begin
              state_q      <= StIdle;
              lambda_rdy_q <= 1'b1;
              chien_vld_q  <= 1'b0;
            end else begin
              base_q <= base_q + SYMB_WIDTH'(R);
              for (int i = 0; i <= T_LEN; i++) term_q[i] <= step_term[i];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_chien_ctrl.sv
// Bench for rs_chien_ctrl: directed and random codewords checked chunk by chunk against a
// log/antilog-table evaluation of Lambda at every alpha^-j.
module tb_rs_chien_ctrl;
  localparam int unsigned R  = 4;
  localparam int unsigned NL = 255;
  localparam int unsigned C  = (NL + R - 1) / R;
  localparam int unsigned TL = 8;

  typedef logic [TL:0][7:0] poly_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned errors = 0;
  int unsigned checks = 0;

  rs_chien_ctrl_if #(.ROOTS_PER_CYCLE(R)) bus ();
  rs_chien_ctrl #(.ROOTS_PER_CYCLE(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]   gexp [255];
  int           glog [256];
  logic [R-1:0] exp_mask [C];
  logic [7:0]   exp_cnt  [C];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(logic [7:0] a, logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Expected mask per chunk and running error count after each chunk.
  task automatic build_model(input poly_t lam);
    int cnt;
    for (int c = 0; c < C; c++) exp_mask[c] = '0;
    cnt = 0;
    for (int j = 0; j < NL; j++) begin
      int e;
      logic [7:0] s;
      e = (255 - j) % 255;
      s = 8'h00;
      for (int i = 0; i <= TL; i++) s = s ^ m_mul(lam[i], gexp[(e * i) % 255]);
      if (s == 8'h00) exp_mask[j / R][j % R] = 1'b1;
    end
    for (int c = 0; c < C; c++) begin
      for (int k = 0; k < R; k++) cnt += int'(exp_mask[c][k]);
      exp_cnt[c] = 8'(cnt);
    end
  endtask

  // Runs one codeword starting from a negedge in IDLE. stop_at >= 0 asserts rst at that chunk.
  task automatic run_cw(input poly_t lam, input logic [7:0] deg, input bit stall,
                        input int stop_at, output logic [7:0] fin_cnt, output logic fin_fail);
    int hs;
    int guard;
    bit done;
    bit prev_stall;
    bit rdy;
    logic [7:0] sb, sc;
    logic [R-1:0] sm;
    logic sl, sf;
    logic exp_fail;
    fin_cnt  = '0;
    fin_fail = 1'b0;
    sb = '0; sc = '0; sm = '0; sl = 1'b0; sf = 1'b0;
    build_model(lam);
    exp_fail = (exp_cnt[C-1] != deg) || (deg > 8'(TL)) || (lam[0] == 8'h00);
    check("idle_lambda_rdy", 32'(bus.lambda_rdy), 32'd1);
    check("idle_chien_vld", 32'(bus.chien_vld), 32'd0);
    bus.lambda     = lam;
    bus.lambda_deg = deg;
    bus.lambda_vld = 1'b1;
    @(negedge clk);
    bus.lambda_vld = 1'b0;
    bus.lambda     = {$urandom, $urandom, $urandom};
    bus.lambda_deg = 8'($urandom);
    hs = 0;
    guard = 0;
    done = 0;
    prev_stall = 0;
    while (!done && hs < int'(C) && guard < 4000) begin
      guard++;
      if (hs == stop_at) begin
        rst = 1'b1;
        bus.chien_rdy  = 1'b0;
        bus.lambda_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.chien_rdy = 1'b1;
        check("rst_lambda_rdy", 32'(bus.lambda_rdy), 32'd1);
        check("rst_chien_vld", 32'(bus.chien_vld), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_chien_last", 32'(bus.chien_last), 32'd0);
        return;
      end
      check("chien_vld", 32'(bus.chien_vld), 32'd1);
      check("busy_lambda_rdy", 32'(bus.lambda_rdy), 32'd0);
      if (prev_stall) begin
        check("hold_base", 32'(bus.chien_base), 32'(sb));
        check("hold_mask", 32'(bus.chien_mask), 32'(sm));
        check("hold_last", 32'(bus.chien_last), 32'(sl));
        check("hold_err_cnt", 32'(bus.err_cnt), 32'(sc));
        check("hold_fail", 32'(bus.fail), 32'(sf));
      end
      check("chien_base", 32'(bus.chien_base), 32'(hs * int'(R)));
      check("chien_mask", 32'(bus.chien_mask), 32'(exp_mask[hs]));
      check("chien_last", 32'(bus.chien_last), 32'(hs == int'(C) - 1));
      check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt[hs]));
      if (hs == int'(C) - 1) check("fail", 32'(bus.fail), 32'(exp_fail));
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.chien_rdy  = rdy;
      bus.lambda_vld = !rdy;  // must be ignored while searching
      bus.lambda     = {$urandom, $urandom, $urandom};
      if (rdy) begin
        if (bus.chien_last) begin
          done     = 1;
          fin_cnt  = bus.err_cnt;
          fin_fail = bus.fail;
        end
        hs++;
        prev_stall = 0;
      end else begin
        sb = bus.chien_base;
        sm = bus.chien_mask;
        sl = bus.chien_last;
        sc = bus.err_cnt;
        sf = bus.fail;
        prev_stall = 1;
      end
      @(negedge clk);
    end
    bus.lambda_vld = 1'b0;
    bus.chien_rdy  = 1'b1;
    check("handshakes", 32'(hs), 32'(C));
    check("last_seen", 32'(done), 32'd1);
    check("after_lambda_rdy", 32'(bus.lambda_rdy), 32'd1);
    check("after_chien_vld", 32'(bus.chien_vld), 32'd0);
  endtask

  initial begin
    poly_t lam;
    logic [7:0] fc;
    logic ff;
    logic [7:0] v;
    v = 8'h01;
    glog[0] = 0;
    for (int e = 0; e < 255; e++) begin
      gexp[e] = v;
      glog[v] = e;
      v = v[7] ? ((v << 1) ^ 8'h1D) : (v << 1);
    end

    rst = 1'b1;
    bus.lambda_vld = 1'b0;
    bus.lambda     = '0;
    bus.lambda_deg = '0;
    bus.chien_rdy  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_lambda_rdy", 32'(bus.lambda_rdy), 32'd1);
    check("reset_chien_vld", 32'(bus.chien_vld), 32'd0);
    check("reset_chien_base", 32'(bus.chien_base), 32'd0);
    check("reset_chien_mask", 32'(bus.chien_mask), 32'd0);
    check("reset_chien_last", 32'(bus.chien_last), 32'd0);
    check("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("reset_fail", 32'(bus.fail), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Lambda = 1: no roots.
    lam = '0; lam[0] = 8'h01;
    run_cw(lam, 8'd0, 0, -1, fc, ff);
    check("one_cnt", 32'(fc), 32'd0);
    check("one_fail", 32'(ff), 32'd0);

    // Single error at position 5.
    lam = '0; lam[0] = 8'h01; lam[1] = 8'h20;
    run_cw(lam, 8'd1, 0, -1, fc, ff);
    check("single_cnt", 32'(fc), 32'd1);
    check("single_fail", 32'(ff), 32'd0);

    // Two errors at positions 0 and 254.
    lam = '0; lam[0] = 8'h01; lam[1] = 8'h8F; lam[2] = 8'h8E;
    run_cw(lam, 8'd2, 0, -1, fc, ff);
    check("two_cnt", 32'(fc), 32'd2);
    check("two_fail", 32'(ff), 32'd0);

    // Failure cases.
    lam = '0; lam[0] = 8'h01; lam[1] = 8'h20;
    run_cw(lam, 8'd2, 0, -1, fc, ff);
    check("mismatch_cnt", 32'(fc), 32'd1);
    check("mismatch_fail", 32'(ff), 32'd1);
    run_cw(lam, 8'd9, 0, -1, fc, ff);
    check("deg9_fail", 32'(ff), 32'd1);
    lam = '0; lam[1] = 8'h20;
    run_cw(lam, 8'd1, 0, -1, fc, ff);
    check("lam0_fail", 32'(ff), 32'd1);

    // Backpressure on the two-error codeword.
    lam = '0; lam[0] = 8'h01; lam[1] = 8'h8F; lam[2] = 8'h8E;
    run_cw(lam, 8'd2, 1, -1, fc, ff);
    check("bp_cnt", 32'(fc), 32'd2);
    check("bp_fail", 32'(ff), 32'd0);

    // Reset mid-search, then a clean sweep.
    run_cw(lam, 8'd2, 0, 30, fc, ff);
    @(negedge clk);
    lam = '0; lam[0] = 8'h01; lam[1] = 8'h20;
    run_cw(lam, 8'd1, 0, -1, fc, ff);
    check("post_rst_cnt", 32'(fc), 32'd1);
    check("post_rst_fail", 32'(ff), 32'd0);

    // Random locators built from distinct roots.
    for (int t = 0; t < 6; t++) begin
      int d;
      int roots [$];
      poly_t p;
      d = int'($urandom_range(0, TL));
      roots = {};
      while (roots.size() < d) begin
        int j;
        bit dup;
        j = int'($urandom_range(0, NL - 1));
        dup = 0;
        foreach (roots[q]) if (roots[q] == j) dup = 1;
        if (!dup) roots.push_back(j);
      end
      p = '0; p[0] = 8'h01;
      foreach (roots[q]) begin
        for (int i = TL; i >= 1; i--) p[i] = p[i] ^ m_mul(p[i-1], gexp[roots[q]]);
      end
      run_cw(p, 8'(d), bit'($urandom_range(0, 1)), -1, fc, ff);
      check("rand_cnt", 32'(fc), 32'(d));
      check("rand_fail", 32'(ff), 32'd0);
    end

    // Arbitrary locators: whatever roots exist, the model decides.
    for (int t = 0; t < 3; t++) begin
      lam = {$urandom, $urandom, $urandom};
      run_cw(lam, 8'($urandom_range(0, 10)), 1, -1, fc, ff);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
